// File: rtl/viterbi_cmd_seq.sv
// viterbi_cmd_seq
// Command sequencer in front of the Viterbi bus controller. Host register read/write
// commands are queued in a small FIFO, issued one at a time as a single-cycle start pulse
// with operands held stable until finish, and read results are returned over a
// valid/ready response port.
//
// Optional feature: define VIT_SEQ_TIMEOUT_EN to bound the wait for finish to
// TIMEOUT_CYCLES cycles after start; a timeout returns to idle and sets a sticky
// timeout_err. Without the macro the wait is unbounded and timeout_err is 0.
//
// Ports
//   clk, reset_all                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready                  host command handshake
//   cmd_write, cmd_vit, cmd_addr, cmd_data  command fields
//   start                                one-cycle issue pulse to the controller
//   is_write, vit_num, in_addr, in_data  operands, stable from start until finish
//   finish, return_data                  controller completion and read data
//   rsp_valid/rsp_ready                  read response handshake
//   rsp_data, rsp_vit, rsp_addr          read result and its origin
//   busy                                 FIFO non-empty or operation in progress
//   timeout_err                          sticky timeout flag
module viterbi_cmd_seq #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_all,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_vit,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       start,
  output logic       is_write,
  output logic       vit_num,
  output logic [2:0] in_addr,
  output logic [7:0] in_data,
  input  logic       finish,
  input  logic [7:0] return_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_vit,
  output logic [2:0] rsp_addr,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : gen_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef struct packed {
    logic       write;
    logic       vit;
    logic [2:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  cmd_t            fifo_q [FIFO_DEPTH];
  cmd_t            fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  cmd_t            op_q, op_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            push, pop, fifo_nempty, to_hit;

  assign fifo_nempty = (count_q != '0);
  assign cmd_ready   = (count_q != CntW'(FIFO_DEPTH));
  assign push        = cmd_valid && cmd_ready;
  // Pop happens only in idle; the head moves straight into the operand registers.
  assign pop         = (state_q == StIdle) && fifo_nempty;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{write: cmd_write, vit: cmd_vit, addr: cmd_addr, data: cmd_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (fifo_nempty) begin
          op_d    = fifo_q[rd_ptr_q];
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // A finish arriving on the timeout cycle still counts as a completion.
        if (finish) begin
          if (op_q.write) begin
            state_d = StIdle;
          end else begin
            rsp_data_d = return_data;
            state_d    = StResp;
          end
        end else if (to_hit) begin
          state_d = StIdle;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef VIT_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           terr_q, terr_d;

  // The counter is zero in the first WAIT cycle (start + 1), so reaching
  // TIMEOUT_CYCLES - 2 marks the last cycle; the flag is visible TIMEOUT_CYCLES after start.
  assign to_hit = (state_q == StWait) && !finish && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    to_cnt_d = (state_q == StWait) ? to_cnt_q + 1'b1 : '0;
    terr_d   = terr_q | to_hit;
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign start     = (state_q == StIssue);
  assign rsp_valid = (state_q == StResp);
  assign busy      = fifo_nempty || (state_q != StIdle);
  assign is_write  = op_q.write;
  assign vit_num   = op_q.vit;
  assign in_addr   = op_q.addr;
  assign in_data   = op_q.data;
  // Operands change only on a pop, so they still describe the read held in RESP.
  assign rsp_vit   = op_q.vit;
  assign rsp_addr  = op_q.addr;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_viterbi_cmd_seq.sv
// Testbench for viterbi_cmd_seq: transaction-level model of the host, the FIFO and the
// controller; every output is compared on every cycle, plus directed literal checks.
module tb_viterbi_cmd_seq;
  localparam int unsigned Depth = 4;
  localparam int unsigned ToCyc = 16;
`ifdef VIT_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  typedef struct packed {
    logic       w;
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
  } cmd_t;

  logic       clk = 1'b0;
  logic       reset_all, cmd_valid, cmd_ready, cmd_write, cmd_vit, start;
  logic       is_write, vit_num, finish, rsp_valid, rsp_ready, rsp_vit, busy, timeout_err;
  logic [2:0] cmd_addr, in_addr, rsp_addr;
  logic [7:0] cmd_data, in_data, return_data, rsp_data;

  viterbi_cmd_seq #(.FIFO_DEPTH(Depth), .TIMEOUT_CYCLES(ToCyc)) dut (
    .clk(clk), .reset_all(reset_all), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_vit(cmd_vit), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .start(start), .is_write(is_write), .vit_num(vit_num), .in_addr(in_addr),
    .in_data(in_data), .finish(finish), .return_data(return_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_vit(rsp_vit), .rsp_addr(rsp_addr),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: queued commands, the command in flight and what it is waiting for.
  cmd_t        mq[$];
  cmd_t        cur;
  logic        op_active, start_due, in_wait, rsp_pend, terr_m;
  logic [11:0] exp_rsp;
  int          since_start, fin_at;

  // Stimulus knobs.
  cmd_t        host_q[$];
  int          p_valid, p_rready, lat_min, lat_max;
  logic        hang_next, hang_cur, use_fixed, rst_req;
  logic [7:0]  fixed_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    cur       = '0;
    op_active = 1'b0;
    start_due = 1'b0;
    in_wait   = 1'b0;
    rsp_pend  = 1'b0;
    terr_m    = 1'b0;
    hang_cur  = 1'b0;
  endtask

  // One clock: compare outputs, drive next inputs, advance the model across the edge.
  task automatic cycle();
    cmd_t c;
    logic v, from_host, push, pop, fin_now, rdy_now;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, mq.size() != Depth);
    chk("start", start, start_due);
    chk("busy", busy, (mq.size() != 0) || op_active);
    chk("rsp_valid", rsp_valid, rsp_pend);
    chk("operands", {is_write, vit_num, in_addr, in_data}, cur);
    if (rsp_pend) chk("rsp_fields", {rsp_data, rsp_vit, rsp_addr}, exp_rsp);
    chk("timeout_err", timeout_err, terr_m);

    from_host = 1'b0;
    c = 13'($urandom);
    if (host_q.size() != 0) begin
      c = host_q[0];
      v = 1'b1;
      from_host = 1'b1;
    end else begin
      v = (p_valid > 0) && ($urandom_range(99) < p_valid);
    end
    cmd_valid = v;
    {cmd_write, cmd_vit, cmd_addr, cmd_data} = c;
    fin_now     = in_wait && !hang_cur && (since_start >= fin_at);
    finish      = fin_now || (!in_wait && $urandom_range(7) == 0);
    return_data = (fin_now && use_fixed) ? fixed_rdata : 8'($urandom);
    rdy_now     = $urandom_range(99) < p_rready;
    rsp_ready   = rdy_now;
    reset_all   = rst_req;
    rst_req     = 1'b0;

    if (reset_all) begin
      model_clear();
    end else begin
      push = v && (mq.size() != Depth);
      pop  = !op_active && (mq.size() != 0);
      if (rsp_pend && rdy_now) begin
        rsp_pend  = 1'b0;
        op_active = 1'b0;
      end else if (in_wait) begin
        if (fin_now) begin
          in_wait = 1'b0;
          if (cur.w) op_active = 1'b0;
          else begin
            rsp_pend = 1'b1;
            exp_rsp  = {return_data, cur.v, cur.a};
          end
        end else if (TmoEn && since_start == int'(ToCyc) - 1) begin
          in_wait   = 1'b0;
          op_active = 1'b0;
          terr_m    = 1'b1;
        end else begin
          since_start++;
        end
      end else if (start_due) begin
        start_due   = 1'b0;
        in_wait     = 1'b1;
        since_start = 1;
        fin_at      = $urandom_range(lat_max, lat_min);
        hang_cur    = hang_next;
        hang_next   = 1'b0;
      end
      if (pop) begin
        cur       = mq.pop_front();
        op_active = 1'b1;
        start_due = 1'b1;
      end
      if (push) begin
        mq.push_back(c);
        if (from_host) void'(host_q.pop_front());
      end
    end
  endtask

  initial begin
    int s_at, r_at, t_at, s2_at, n_st;
    int starts[$];
    logic seen_nr, seen_rsp;
    logic [7:0] held;

    reset_all = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_vit = 1'b0;
    cmd_addr = '0; cmd_data = '0; finish = 1'b0; return_data = '0; rsp_ready = 1'b0;
    p_valid = 0; p_rready = 100; lat_min = 4; lat_max = 4;
    hang_next = 1'b0; use_fixed = 1'b0; fixed_rdata = '0; rst_req = 1'b0;
    exp_rsp = '0; since_start = 0; fin_at = 4;
    model_clear();
    repeat (2) @(posedge clk);

    // Reset state, pinned by literals as well.
    cycle();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_operands", {is_write, vit_num, in_addr, in_data}, 0);

    // Single write: start two cycles after the push is driven, no response.
    host_q.push_back('{w: 1'b1, v: 1'b0, a: 3'd3, d: 8'hA5});
    s_at = 0; seen_rsp = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (start && s_at == 0) begin
        s_at = i;
        chk("wr_operands", {is_write, vit_num, in_addr, in_data}, 13'h10A5 | 13'h0300);
      end
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("wr_start_cycle", s_at, 3);
    chk("wr_no_rsp", seen_rsp, 0);

    // Single read: finish four cycles after start, response one cycle later.
    use_fixed = 1'b1; fixed_rdata = 8'h3C;
    host_q.push_back('{w: 1'b0, v: 1'b1, a: 3'd5, d: 8'h00});
    s_at = 0; r_at = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (start && s_at == 0) s_at = i;
      if (rsp_valid && r_at == 0) begin
        r_at = i;
        chk("rd_rsp", {rsp_data, rsp_vit, rsp_addr}, {8'h3C, 1'b1, 3'd5});
      end
    end
    chk("rd_start_cycle", s_at, 3);
    chk("rd_rsp_cycle", r_at, 8);

    // Back-pressure with a slow controller; issue order must follow push order.
    lat_min = 12; lat_max = 12; use_fixed = 1'b0; seen_nr = 1'b0;
    for (int k = 1; k <= 6; k++) host_q.push_back('{w: 1'b1, v: k[0], a: k[2:0], d: 8'(k)});
    for (int i = 0; i < 150; i++) begin
      cycle();
      if (start) starts.push_back(int'(in_data));
      if (!cmd_ready) seen_nr = 1'b1;
    end
    chk("bp_not_ready_seen", seen_nr, 1);
    chk("bp_issue_count", starts.size(), 6);
    for (int k = 0; k < starts.size(); k++) chk("bp_issue_order", starts[k], k + 1);

    // Response stall: response held for 10 cycles with no new issue.
    lat_min = 4; lat_max = 6; p_rready = 0;
    host_q.push_back('{w: 1'b0, v: 1'b0, a: 3'd2, d: 8'h00});
    host_q.push_back('{w: 1'b1, v: 1'b1, a: 3'd7, d: 8'h5A});
    r_at = 0;
    for (int i = 0; i < 30 && r_at == 0; i++) begin
      cycle();
      if (rsp_valid) r_at = 1;
    end
    chk("stall_rsp_seen", r_at, 1);
    held = rsp_data; n_st = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (start) n_st++;
      chk("stall_rsp_held", {rsp_valid, rsp_data}, {1'b1, held});
    end
    chk("stall_no_start", n_st, 0);
    p_rready = 100; n_st = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (start) n_st++;
    end
    chk("stall_resume_start", n_st, 1);

    // Reset during WAIT with commands still queued.
    lat_min = 10; lat_max = 10;
    for (int k = 0; k < 3; k++) host_q.push_back('{w: 1'b1, v: 1'b0, a: 3'd1, d: 8'(8'hC0 + k)});
    s_at = 0;
    for (int i = 0; i < 20 && s_at == 0; i++) begin
      cycle();
      if (start) s_at = 1;
    end
    chk("rst_mid_start_seen", s_at, 1);
    cycle();
    cycle();
    rst_req = 1'b1;
    cycle();
    cycle();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_start", start, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    n_st = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (start) n_st++;
    end
    chk("rst_mid_no_stale", n_st, 0);

`ifdef VIT_SEQ_TIMEOUT_EN
    // Suppressed finish: flag 16 cycles after start, next command issued after.
    lat_min = 4; lat_max = 4; hang_next = 1'b1;
    host_q.push_back('{w: 1'b1, v: 1'b0, a: 3'd4, d: 8'h11});
    host_q.push_back('{w: 1'b1, v: 1'b1, a: 3'd6, d: 8'h22});
    s_at = 0; t_at = 0; s2_at = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (start && s_at == 0) s_at = i;
      else if (start && s2_at == 0) begin
        s2_at = i;
        chk("tmo_next_data", in_data, 8'h22);
      end
      if (timeout_err && t_at == 0) t_at = i;
    end
    chk("tmo_flag_delay", t_at - s_at, 16);
    chk("tmo_next_issue", s2_at - s_at, 17);
`else
    s2_at = 0; t_at = 0;
`endif

    // Randomized traffic.
    p_valid = 40; p_rready = 60; lat_min = 4; lat_max = 10;
    for (int i = 0; i < 3000; i++) begin
      rst_req = ($urandom_range(499) == 0);
      if (TmoEn && $urandom_range(19) == 0) hang_next = 1'b1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
